// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared APB types for the local bus fabric.
//   addr_t      : APB address (PADDR width)
//   data_t      : APB data (PWDATA / PRDATA width)
//   apb_state_e : transfer phase of an APB master (IDLE, SETUP, ACCESS)
// -----------------------------------------------------------------------------
package apb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// apb_rr_arbiter
// Combinational round-robin pick: the first asserted request found when
// searching upward from ptr, wrapping modulo NUM_REQ. The pointer itself is
// held by the instantiating block.
//   req     in  NUM_REQ  pending requests
//   ptr     in  IDX_W    index with highest priority this cycle
//   en      in  1        grant enable; gnt is all-zero when low
//   gnt     out NUM_REQ  one-hot grant
//   gnt_idx out IDX_W    index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module apb_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   gnt_idx
);

   // One extra bit so ptr + offset never overflows before the wrap.
   localparam logic [IDX_W:0] NUM_W = (IDX_W+1)'(NUM_REQ);

   logic [IDX_W:0]   k_sum;
   logic [IDX_W-1:0] k;
   logic             found;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      k_sum   = '0;
      k       = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         k_sum = {1'b0, ptr} + (IDX_W+1)'(i);
         if (k_sum >= NUM_W) begin
            k_sum = k_sum - NUM_W;
         end
         k = k_sum[IDX_W-1:0];
         if (en && !found && req[k]) begin
            gnt[k]  = 1'b1;
            gnt_idx = k;
            found   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_rr_master.sv
// -----------------------------------------------------------------------------
// apb_rr_master
// APB master shared by NUM_REQ local requesters with round-robin arbitration.
// Each accepted request runs one APB transfer (IDLE -> SETUP -> ACCESS) and
// completes with a one-cycle one-hot rsp_valid strobe to its requester.
//
// Request handshake: a requester raises req_valid[i] with req_write/addr/wdata
// and holds them stable; the request is accepted on the PCLK edge where
// req_ready[i] is high. req_ready is combinational, one-hot, and only ever
// high while the master is IDLE and out of reset.
//
// Ports
//   PCLK, PRESETn                 clock, synchronous active-low reset
//   req_valid/write/addr/wdata    per-requester request channel
//   req_ready                     one-hot accept strobe
//   rsp_valid, rsp_rdata, rsp_err registered completion (rdata 0 when idle)
//   PSEL, PENABLE, PWRITE, PADDR, PWDATA, PREADY, PSLVERR, PRDATA  APB bus
//   dbg_state                     current transfer phase
//
// Build option: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles with PREADY low (completes with rsp_err=1).
// -----------------------------------------------------------------------------
module apb_rr_master
   import apb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [NUM_REQ-1:0] req_write,
   input  addr_t              req_addr  [NUM_REQ],
   input  data_t              req_wdata [NUM_REQ],
   output logic [NUM_REQ-1:0] req_ready,
   output logic [NUM_REQ-1:0] rsp_valid,
   output data_t              rsp_rdata,
   output logic               rsp_err,
   output logic               PSEL,
   output logic               PENABLE,
   output logic               PWRITE,
   output addr_t              PADDR,
   output data_t              PWDATA,
   input  logic               PREADY,
   input  logic               PSLVERR,
   input  data_t              PRDATA,
   output apb_state_e         dbg_state
);

   localparam int             IDX_W    = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ-1);

   if (NUM_REQ < 2) begin : g_bad_num_req
      $error("apb_rr_master: NUM_REQ must be at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("apb_rr_master: TIMEOUT_CYCLES must be at least 1");
   end

   apb_state_e         state_q, state_d;
   logic [IDX_W-1:0]   ptr_q;
   logic [NUM_REQ-1:0] gnt_q;
   addr_t              paddr_q;
   data_t              pwdata_q;
   logic               pwrite_q;
   logic [NUM_REQ-1:0] rsp_valid_q;
   logic               rsp_err_q;
   data_t              rsp_rdata_q;

   logic [NUM_REQ-1:0] gnt;
   logic [IDX_W-1:0]   gnt_idx;
   logic               arb_en;
   logic               accept;
   logic               xfer_done;
   logic               to_hit;

   // Grants are blocked while reset is asserted so nothing is accepted in a
   // cycle whose edge is about to discard it.
   assign arb_en    = (state_q == IDLE) && PRESETn;
   assign accept    = |gnt;
   assign xfer_done = (state_q == ACCESS) && PREADY;

   apb_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .en      (arb_en),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

`ifdef APB_TIMEOUT_EN
   localparam int            TO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   logic [TO_W-1:0] to_cnt_q;

   // The cycle holding count TIMEOUT_CYCLES-1 is itself the last allowed
   // PREADY-low cycle, so the abort happens on its closing edge.
   assign to_hit = (state_q == ACCESS) && !PREADY && (to_cnt_q == TO_LAST);

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         to_cnt_q <= '0;
      end else if (accept) begin
         to_cnt_q <= '0;
      end else if ((state_q == ACCESS) && !PREADY) begin
         to_cnt_q <= to_cnt_q + TO_W'(1);
      end
   end
`else
   assign to_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (xfer_done || to_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         gnt_q       <= '0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         pwrite_q    <= 1'b0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
         if (accept) begin
            gnt_q    <= gnt;
            paddr_q  <= req_addr[gnt_idx];
            pwdata_q <= req_wdata[gnt_idx];
            pwrite_q <= req_write[gnt_idx];
            ptr_q    <= (gnt_idx == LAST_IDX) ? '0 : gnt_idx + IDX_W'(1);
         end
         if (xfer_done) begin
            rsp_valid_q <= gnt_q;
            rsp_err_q   <= PSLVERR;
            rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
         end else if (to_hit) begin
            rsp_valid_q <= gnt_q;
            rsp_err_q   <= 1'b1;
         end
      end
   end

   assign req_ready = gnt;
   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;
   assign PSEL      = (state_q != IDLE);
   assign PENABLE   = (state_q == ACCESS);
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// -----------------------------------------------------------------------------
// tb_apb_rr_master
// Self-checking bench for apb_rr_master: a table of single transfers, a
// cycle-exact zero-wait write, round-robin fairness, reset during ACCESS and
// the PREADY-stuck case (behaviour depends on APB_TIMEOUT_EN).
// -----------------------------------------------------------------------------
module tb_apb_rr_master;
   import apb_pkg::*;

   localparam int NR = 4;
   localparam int TO = 16;
   localparam int EW = NR + 1 + DATA_W;

   // ---------------- clock / reset ----------------
   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic [NR-1:0] req_valid = '0;
   logic [NR-1:0] req_write = '0;
   addr_t         req_addr  [NR];
   data_t         req_wdata [NR];
   logic [NR-1:0] req_ready, rsp_valid;
   data_t         rsp_rdata;
   logic          rsp_err;
   logic          PSEL, PENABLE, PWRITE;
   addr_t         PADDR;
   data_t         PWDATA;
   logic          PREADY = 1'b0;
   logic          PSLVERR = 1'b0;
   data_t         PRDATA = '0;
   apb_state_e    dbg_state;

   initial forever #5 PCLK = ~PCLK;

   apb_rr_master #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA),
      .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
      .dbg_state(dbg_state)
   );

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: bounded wait expired (t=%0t)", name, $time);
   endtask

   // ---------------- APB slave model ----------------
   // Inserts slv_wait low-PREADY ACCESS cycles, then completes.
   int    slv_wait = 0;
   data_t slv_rdata = '0;
   bit    slv_err = 1'b0;
   int    slv_cnt = 0;

   always @(negedge PCLK) begin
      if (PSEL && PENABLE) begin
         PREADY  = (slv_cnt >= slv_wait);
         PSLVERR = PREADY ? slv_err : 1'b0;
         PRDATA  = PREADY ? slv_rdata : '0;
         slv_cnt++;
      end else begin
         PREADY  = 1'b0;
         PSLVERR = 1'b0;
         PRDATA  = '0;
         slv_cnt = 0;
      end
   end

   function automatic bit times_out(input int w);
`ifdef APB_TIMEOUT_EN
      return (w >= TO);
`else
      return 1'b0;
`endif
   endfunction

   function automatic int exp_acc(input int w);
      return times_out(w) ? TO : w + 1;
   endfunction

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];

   always @(negedge PCLK) begin
      logic [EW-1:0] e;
      logic          wr;
      if (!PRESETn) begin
         exp_q.delete();
      end else begin
         if (rsp_valid != '0) begin
            if (exp_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL rsp_unexpected: got rsp_valid=0x%0h, expected none", rsp_valid);
            end else begin
               e = exp_q.pop_front();
               check("rsp", {rsp_valid, rsp_err, rsp_rdata}, e);
            end
         end else begin
            check("rdata_idle_zero", rsp_rdata, 0);
         end
         if (PSEL) check("ready_busy_zero", req_ready, 0);
         if (req_ready != '0) begin
            wr = 1'b0;
            for (int i = 0; i < NR; i++) if (req_ready[i]) wr = req_write[i];
            e = {req_ready,
                 times_out(slv_wait) ? 1'b1 : slv_err,
                 (times_out(slv_wait) || wr) ? data_t'(0) : slv_rdata};
            exp_q.push_back(e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   typedef struct {
      int    r;
      bit    wr;
      addr_t addr;
      data_t wdata;
      int    wait_n;
      data_t rdata;
      bit    err;
   } vec_t;

   task automatic do_reset();
      req_valid = '0;
      PRESETn = 1'b0;
      repeat (2) @(posedge PCLK);
      #1 PRESETn = 1'b1;
   endtask

   task automatic do_xfer(input vec_t v);
      int acc = 0;
      int budget = 0;
      bit granted = 1'b0;
      bit done = 1'b0;
      bit bus_ok = 1'b1;
      slv_wait  = v.wait_n;
      slv_rdata = v.rdata;
      slv_err   = v.err;
      @(posedge PCLK);
      #1;
      req_valid[v.r] = 1'b1;
      req_write[v.r] = v.wr;
      req_addr[v.r]  = v.addr;
      req_wdata[v.r] = v.wdata;
      while (!done && budget < 200) begin
         @(negedge PCLK);
         budget++;
         if (!granted && req_ready != '0) begin
            check("grant", req_ready, 64'(1) << v.r);
            granted = 1'b1;
         end
         if (PSEL && (PADDR !== v.addr || PWRITE !== v.wr)) bus_ok = 1'b0;
         if (PSEL && v.wr && PWDATA !== v.wdata) bus_ok = 1'b0;
         if (PSEL && PENABLE) acc++;
         if (rsp_valid != '0) done = 1'b1;
         @(posedge PCLK);
         #1;
         if (granted) req_valid[v.r] = 1'b0;
      end
      if (!done) fail_now("xfer_done");
      check("access_cycles", acc, exp_acc(v.wait_n));
      check("bus_stable", bus_ok, 1);
   endtask

   // ---------------- test sequence ----------------
   vec_t vecs[8];

   initial begin
      int n, cyc, last, budget;

      for (int i = 0; i < NR; i++) begin
         req_addr[i]  = '0;
         req_wdata[i] = '0;
      end

      vecs[0] = '{r:0, wr:1, addr:32'h10, wdata:32'hDEADBEEF, wait_n:0, rdata:32'h0, err:0};
      vecs[1] = '{r:1, wr:0, addr:32'h20, wdata:32'h0, wait_n:3, rdata:32'h12345678, err:0};
      vecs[2] = '{r:2, wr:1, addr:32'h30, wdata:32'h0BADF00D, wait_n:0, rdata:32'h0, err:1};
      vecs[3] = '{r:3, wr:0, addr:32'h40, wdata:32'h0, wait_n:1, rdata:32'hCAFEF00D, err:1};
      for (int i = 4; i < 8; i++) begin
         vecs[i].r      = int'($urandom_range(NR - 1, 0));
         vecs[i].wr     = 1'($urandom_range(1, 0));
         vecs[i].addr   = addr_t'($urandom_range(16'hFFFF, 0)) & ~addr_t'(3);
         vecs[i].wdata  = data_t'($urandom);
         vecs[i].wait_n = int'($urandom_range(5, 0));
         vecs[i].rdata  = data_t'($urandom);
         vecs[i].err    = 1'b0;
      end

      // Reset state.
      do_reset();
      @(negedge PCLK);
      check("rst_psel", PSEL, 0);
      check("rst_penable", PENABLE, 0);
      check("rst_pwrite", PWRITE, 0);
      check("rst_paddr", PADDR, 0);
      check("rst_pwdata", PWDATA, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_state", dbg_state, IDLE);

      // Cycle-exact zero-wait write from requester 0.
      slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h0;
      @(posedge PCLK);
      #1;
      req_valid[0] = 1'b1; req_write[0] = 1'b1;
      req_addr[0] = 32'h10; req_wdata[0] = 32'hDEADBEEF;
      @(negedge PCLK);
      check("zw_ready", req_ready, 4'b0001);
      check("zw_psel_c0", PSEL, 0);
      @(posedge PCLK);
      #1 req_valid[0] = 1'b0;
      @(negedge PCLK);
      check("zw_setup", {PSEL, PENABLE, PWRITE}, 3'b101);
      check("zw_state", dbg_state, SETUP);
      check("zw_paddr", PADDR, 32'h10);
      check("zw_pwdata", PWDATA, 32'hDEADBEEF);
      @(negedge PCLK);
      check("zw_access", {PSEL, PENABLE}, 2'b11);
      @(negedge PCLK);
      check("zw_rsp_valid", rsp_valid, 4'b0001);
      check("zw_rsp_err", rsp_err, 0);
      check("zw_psel_done", PSEL, 0);

      // Table of single transfers.
      for (int i = 0; i < 8; i++) do_xfer(vecs[i]);

      // Fairness: all requesters held valid for 8 grants.
      do_reset();
      slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hA5A50000;
      @(posedge PCLK);
      #1;
      for (int i = 0; i < NR; i++) begin
         req_write[i] = 1'b0;
         req_addr[i]  = addr_t'(32'h100 + 4 * i);
      end
      req_valid = '1;
      n = 0; cyc = 0; last = 0; budget = 0;
      while (n < 8 && budget < 100) begin
         @(negedge PCLK);
         budget++;
         if (req_ready != '0) begin
            check("fair_order", req_ready, 64'(1) << (n % NR));
            if (n > 0) check("fair_spacing", cyc - last, 3);
            last = cyc;
            n++;
         end
         cyc++;
      end
      if (n < 8) fail_now("fair_grants");
      @(posedge PCLK);
      #1 req_valid = '0;
      repeat (6) @(posedge PCLK);

      // Reset during ACCESS: transfer dropped, pointer back to requester 0.
      do_reset();
      slv_wait = 50;
      @(posedge PCLK);
      #1;
      req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 32'h50;
      @(posedge PCLK);
      #1 req_valid[1] = 1'b0;
      budget = 0;
      do begin
         @(negedge PCLK);
         budget++;
      end while (!PENABLE && budget < 10);
      if (!PENABLE) fail_now("rst_mid_access_entry");
      @(posedge PCLK);
      #1;
      PRESETn = 1'b0;
      slv_wait = 0; slv_rdata = 32'h0000BEEF;
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[0] = 32'h60;
      req_valid[3] = 1'b1; req_write[3] = 1'b0; req_addr[3] = 32'h70;
      @(posedge PCLK);
      #1 PRESETn = 1'b1;
      @(negedge PCLK);
      check("rstmid_bus", {PSEL, PENABLE}, 2'b00);
      check("rstmid_rsp", rsp_valid, 0);
      check("rstmid_grant0", req_ready, 4'b0001);
      @(posedge PCLK);
      #1 req_valid[0] = 1'b0;
      budget = 0;
      do begin
         @(negedge PCLK);
         budget++;
      end while (req_ready == '0 && budget < 10);
      check("rstmid_grant3", req_ready, 4'b1000);
      @(posedge PCLK);
      #1 req_valid[3] = 1'b0;
      repeat (6) @(posedge PCLK);

      // PREADY stuck low.
`ifdef APB_TIMEOUT_EN
      do_xfer('{r:2, wr:0, addr:32'h80, wdata:32'h0, wait_n:1000, rdata:32'hFFFFFFFF, err:0});
`else
      slv_wait = 1000;
      @(posedge PCLK);
      #1;
      req_valid[2] = 1'b1; req_write[2] = 1'b0; req_addr[2] = 32'h80;
      @(posedge PCLK);
      #1 req_valid[2] = 1'b0;
      @(negedge PCLK);
      n = 0;
      for (int i = 0; i < 110; i++) begin
         @(negedge PCLK);
         if (PENABLE && rsp_valid == '0) n++;
      end
      check("stuck_penable_cycles", n, 110);
      do_reset();
      slv_wait = 0;
`endif

      repeat (3) @(posedge PCLK);
      check("queue_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
      $fatal(1);
   end

endmodule
